// File: rtl/xbus_mcast_tx_if.sv
// Input stream plus per-PE multicast handshake of the row X-bus transmitter.
// The master side is the transmitter; the slave side is the buffer/PE environment.
interface xbus_mcast_tx_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = 4,
    parameter int NUM_PE     = 9
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic [ID_WIDTH-1:0]   in_row_tag;
    logic [ID_WIDTH-1:0]   in_col_tag;
    logic                  in_last;
    logic [DATA_WIDTH-1:0] bus_data;
    logic [NUM_PE-1:0]     pe_en;
    logic [NUM_PE-1:0]     pe_ready;

    modport master (
        input  in_valid, in_data, in_row_tag, in_col_tag, in_last, pe_ready,
        output in_ready, bus_data, pe_en
    );

    modport slave (
        output in_valid, in_data, in_row_tag, in_col_tag, in_last, pe_ready,
        input  in_ready, bus_data, pe_en
    );
endinterface

// File: rtl/xbus_mcast_tx.sv
// Row X-bus transmitter: multicasts each tagged word to every PE whose row/column
// IDs match, retiring the word only once all targeted PEs have accepted it.
module xbus_mcast_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_ROW    = 3,
    parameter int NUM_COL    = 3,
    parameter int ID_WIDTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       cfg_we,
    input  logic                       cfg_sel,
    input  logic [$clog2(NUM_ROW)-1:0] cfg_row,
    input  logic [$clog2(NUM_COL)-1:0] cfg_col,
    input  logic [ID_WIDTH-1:0]        cfg_id,
    xbus_mcast_tx_if.master            xb,
    output logic                       busy,
    output logic                       done,
    output logic                       drop,
    output logic [15:0]                beat_cnt
);
    localparam int NUM_PE = NUM_ROW * NUM_COL;
    localparam int PE_IW  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]            state;
    logic [DATA_WIDTH-1:0] data_q;
    logic [ID_WIDTH-1:0]   row_tag_q;
    logic [ID_WIDTH-1:0]   col_tag_q;
    logic                  last_q;
    logic [NUM_PE-1:0]     acked;

    logic [ID_WIDTH-1:0]   rowid [NUM_ROW];
    logic [ID_WIDTH-1:0]   colid [NUM_PE];

    logic [NUM_PE-1:0]     tgt;
    logic [NUM_PE-1:0]     pe_en_c;
    logic [NUM_PE-1:0]     accepted;
    logic                  sending;
    logic                  beat_done;
    logic                  ready_c;
    logic                  take;
    logic                  cfg_wr;
    logic [PE_IW-1:0]      cfg_pe;
    logic                  cfg_row_ok;
    logic                  cfg_col_ok;

    always_comb begin
        tgt = '0;
        for (int r = 0; r < NUM_ROW; r++) begin
            for (int c = 0; c < NUM_COL; c++) begin
                tgt[r*NUM_COL+c] = (rowid[r] == row_tag_q) && (colid[r*NUM_COL+c] == col_tag_q);
            end
        end
    end

    // Already-acked PEs are withdrawn so a word is never offered twice to the same PE.
    always_comb begin
        pe_en_c = '0;
        if (sending && !flush) begin
            pe_en_c = tgt & ~acked;
        end
    end

    assign sending   = (state == SEND);
    assign accepted  = pe_en_c & xb.pe_ready;
    assign beat_done = sending && (((acked | accepted) & tgt) == tgt);
    assign ready_c   = !flush && (!sending || beat_done);
    assign take      = xb.in_valid && ready_c;

    assign xb.in_ready = ready_c;
    assign xb.pe_en    = pe_en_c;
    assign xb.bus_data = data_q;
    assign busy        = sending;

    assign cfg_wr     = cfg_we && !flush && (state == IDLE);
    assign cfg_row_ok = int'(cfg_row) < NUM_ROW;
    assign cfg_col_ok = int'(cfg_col) < NUM_COL;
    assign cfg_pe     = PE_IW'(int'(cfg_row) * NUM_COL + int'(cfg_col));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_ROW; r++) begin
                rowid[r] <= '0;
            end
            for (int i = 0; i < NUM_PE; i++) begin
                colid[i] <= '0;
            end
        end else if (cfg_wr) begin
            if (!cfg_sel) begin
                if (cfg_row_ok) begin
                    rowid[cfg_row] <= cfg_id;
                end
            end else if (cfg_row_ok && cfg_col_ok) begin
                colid[cfg_pe] <= cfg_id;
            end
        end
    end

    // A retiring word may be replaced in the same cycle, giving one word per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            data_q    <= '0;
            row_tag_q <= '0;
            col_tag_q <= '0;
            last_q    <= 1'b0;
            acked     <= '0;
            beat_cnt  <= '0;
            done      <= 1'b0;
            drop      <= 1'b0;
        end else begin
            done <= 1'b0;
            drop <= 1'b0;
            if (flush) begin
                state    <= IDLE;
                acked    <= '0;
                beat_cnt <= '0;
            end else begin
                if (sending) begin
                    acked <= acked | accepted;
                end
                if (beat_done) begin
                    beat_cnt <= last_q ? 16'd0 : beat_cnt + 16'd1;
                    done     <= last_q;
                    drop     <= (tgt == '0);
                end
                if (take) begin
                    data_q    <= xb.in_data;
                    row_tag_q <= xb.in_row_tag;
                    col_tag_q <= xb.in_col_tag;
                    last_q    <= xb.in_last;
                    acked     <= '0;
                    state     <= SEND;
                end else if (beat_done) begin
                    state <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_xbus_mcast_tx.sv
// Directed bench for xbus_mcast_tx: a word/delivery-set model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_xbus_mcast_tx;
    localparam int NR  = 3;
    localparam int NC  = 3;
    localparam int NPE = NR * NC;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        cfg_we;
    logic        cfg_sel;
    logic [1:0]  cfg_row;
    logic [1:0]  cfg_col;
    logic [3:0]  cfg_id;
    logic        busy;
    logic        done;
    logic        drop;
    logic [15:0] beat_cnt;

    int checks = 0;
    int passes = 0;
    int off0   = 0;

    xbus_mcast_tx_if #(.DATA_WIDTH(16), .ID_WIDTH(4), .NUM_PE(NPE)) bi ();

    xbus_mcast_tx #(.DATA_WIDTH(16), .NUM_ROW(NR), .NUM_COL(NC), .ID_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_row(cfg_row), .cfg_col(cfg_col), .cfg_id(cfg_id),
        .xb(bi), .busy(busy), .done(done), .drop(drop), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    // Model: tables, the word in flight, and which targeted PEs already received it.
    int          mRow [NR] = '{default: 0};
    int          mCol [NPE] = '{default: 0};
    bit          mValid = 1'b0;
    logic [15:0] mData = '0;
    logic [3:0]  mRt = '0;
    logic [3:0]  mCt = '0;
    bit          mLast = 1'b0;
    bit          mGot [NPE] = '{default: 1'b0};
    logic [15:0] mCnt = '0;
    bit          mDone = 1'b0;
    bit          mDrop = 1'b0;

    logic [NPE-1:0] cOffer, uOffer;
    bit             cFin, uFin;
    int             cN, uN;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            passes++;
        end
    endtask

    function automatic void evalWord(output logic [NPE-1:0] offer, output bit fin, output int ntg);
        int remaining = 0;
        offer = '0;
        ntg = 0;
        for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < NC; c++) begin
                if (mValid && mRow[r] == int'(mRt) && mCol[r*NC+c] == int'(mCt)) begin
                    ntg++;
                    if (!mGot[r*NC+c]) begin
                        if (!flush) offer[r*NC+c] = 1'b1;
                        if (!(offer[r*NC+c] && bi.pe_ready[r*NC+c])) remaining++;
                    end
                end
            end
        end
        fin = mValid && (remaining == 0);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NR; i++) mRow[i] = 0;
            for (int i = 0; i < NPE; i++) begin
                mCol[i] = 0;
                mGot[i] = 1'b0;
            end
            mValid = 1'b0; mData = '0; mCnt = '0; mDone = 1'b0; mDrop = 1'b0;
        end else begin
            mDone = 1'b0;
            mDrop = 1'b0;
            if (flush) begin
                mValid = 1'b0;
                mCnt = '0;
                for (int i = 0; i < NPE; i++) mGot[i] = 1'b0;
            end else begin
                evalWord(uOffer, uFin, uN);
                for (int i = 0; i < NPE; i++) if (uOffer[i] && bi.pe_ready[i]) mGot[i] = 1'b1;
                if (uFin) begin
                    mDone = mLast;
                    mDrop = (uN == 0);
                    mCnt  = mLast ? 16'd0 : mCnt + 16'd1;
                end
                if (!mValid && cfg_we) begin
                    if (!cfg_sel) mRow[cfg_row] = int'(cfg_id);
                    else mCol[int'(cfg_row)*NC+int'(cfg_col)] = int'(cfg_id);
                end
                if (bi.in_valid && (!mValid || uFin)) begin
                    mValid = 1'b1; mData = bi.in_data; mRt = bi.in_row_tag;
                    mCt = bi.in_col_tag; mLast = bi.in_last;
                    for (int i = 0; i < NPE; i++) mGot[i] = 1'b0;
                end else if (uFin) begin
                    mValid = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        evalWord(cOffer, cFin, cN);
        checkOutput("mdl_in_ready", 32'(bi.in_ready), 32'(!flush && (!mValid || cFin)));
        checkOutput("mdl_pe_en", 32'(bi.pe_en), 32'(cOffer));
        checkOutput("mdl_busy", 32'(busy), 32'(mValid));
        if (mValid) checkOutput("mdl_bus_data", 32'(bi.bus_data), 32'(mData));
        checkOutput("mdl_done", 32'(done), 32'(mDone));
        checkOutput("mdl_drop", 32'(drop), 32'(mDrop));
        checkOutput("mdl_beat_cnt", 32'(beat_cnt), 32'(mCnt));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] d, input logic [3:0] rt,
                                 input logic [3:0] ct, input logic last);
        bi.in_valid = v; bi.in_data = d; bi.in_row_tag = rt; bi.in_col_tag = ct; bi.in_last = last;
    endtask

    task automatic cfgWrite(input logic sel, input int row, input int col, input int id);
        cfg_we = 1'b1; cfg_sel = sel; cfg_row = 2'(row); cfg_col = 2'(col); cfg_id = 4'(id);
        step();
        cfg_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0;
        cfg_row = '0; cfg_col = '0; cfg_id = '0; bi.pe_ready = '0;
        applyStimulus(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
        step(); step(); mid();
        checkOutput("rst_in_ready", 32'(bi.in_ready), 32'd1);
        checkOutput("rst_pe_en", 32'(bi.pe_en), 32'd0);
        checkOutput("rst_bus_data", 32'(bi.bus_data), 32'd0);
        checkOutput("rst_busy_done_drop", {29'd0, busy, done, drop}, 32'd0);
        checkOutput("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        step();
        rst = 1'b0;

        // Rows 0,1,2 and cols[r][c]=c, then unicast to row 1 col 2 (PE 5).
        for (int r = 0; r < NR; r++) cfgWrite(1'b0, r, 0, r);
        for (int i = 0; i < NPE; i++) cfgWrite(1'b1, i / NC, i % NC, i % NC);
        bi.pe_ready = '1;
        applyStimulus(1'b1, 16'h1234, 4'd1, 4'd2, 1'b0);
        step();
        applyStimulus(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
        mid();
        checkOutput("uni_pe_en", 32'(bi.pe_en), 32'h020);
        checkOutput("uni_in_ready", 32'(bi.in_ready), 32'd1);
        checkOutput("uni_bus_data", 32'(bi.bus_data), 32'h1234);
        step(); mid();
        checkOutput("uni_beat_cnt", 32'(beat_cnt), 32'd1);
        checkOutput("uni_idle_pe_en", 32'(bi.pe_en), 32'd0);
        step();

        // All columns 0, multicast to row 0 with staggered readies.
        for (int i = 0; i < NPE; i++) cfgWrite(1'b1, i / NC, i % NC, 0);
        bi.pe_ready = '0;
        applyStimulus(1'b1, 16'hABCD, 4'd0, 4'd0, 1'b0);
        step();
        applyStimulus(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
        bi.pe_ready = 9'b000000001;
        mid(); if (bi.pe_en[0]) off0++;
        checkOutput("mc_c1_pe_en", 32'(bi.pe_en), 32'b111);
        checkOutput("mc_c1_in_ready", 32'(bi.in_ready), 32'd0);
        step(); bi.pe_ready = '0;
        mid(); if (bi.pe_en[0]) off0++;
        checkOutput("mc_c2_pe_en", 32'(bi.pe_en), 32'b110);
        step(); bi.pe_ready = 9'b000000010;
        mid(); if (bi.pe_en[0]) off0++;
        checkOutput("mc_c3_pe_en", 32'(bi.pe_en), 32'b110);
        step(); bi.pe_ready = 9'b000000100;
        mid(); if (bi.pe_en[0]) off0++;
        checkOutput("mc_c4_pe_en", 32'(bi.pe_en), 32'b100);
        checkOutput("mc_c4_in_ready", 32'(bi.in_ready), 32'd1);
        step(); bi.pe_ready = '0;
        mid();
        checkOutput("mc_c5_pe_en", 32'(bi.pe_en), 32'd0);
        checkOutput("mc_beat_cnt", 32'(beat_cnt), 32'd2);
        checkOutput("mc_bit0_offers", 32'(off0), 32'd1);
        step();

        // Four back-to-back words, last on the fourth.
        bi.pe_ready = '1;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 16'h0100 + 16'(k), 4'd0, 4'd0, k == 3);
            if (k > 0) begin
                mid();
                checkOutput("b2b_in_ready", 32'(bi.in_ready), 32'd1);
                checkOutput("b2b_bus_data", 32'(bi.bus_data), 32'h0100 + 32'(k - 1));
            end
            step();
        end
        applyStimulus(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
        mid();
        checkOutput("b2b_w4_bus_data", 32'(bi.bus_data), 32'h0103);
        checkOutput("b2b_w4_done_early", 32'(done), 32'd0);
        step(); mid();
        checkOutput("b2b_done", 32'(done), 32'd1);
        checkOutput("b2b_beat_cnt", 32'(beat_cnt), 32'd0);
        step(); mid();
        checkOutput("b2b_done_pulse", 32'(done), 32'd0);
        step();

        // Zero-target word.
        applyStimulus(1'b1, 16'hDEAD, 4'd7, 4'd0, 1'b0);
        step();
        applyStimulus(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
        mid();
        checkOutput("drop_pe_en", 32'(bi.pe_en), 32'd0);
        checkOutput("drop_in_ready", 32'(bi.in_ready), 32'd1);
        step(); mid();
        checkOutput("drop_pulse", 32'(drop), 32'd1);
        checkOutput("drop_beat_cnt", 32'(beat_cnt), 32'd1);
        step(); mid();
        checkOutput("drop_pulse_end", 32'(drop), 32'd0);
        step();

        // Stalled word, ignored config write, then flush.
        bi.pe_ready = '0;
        applyStimulus(1'b1, 16'h5555, 4'd0, 4'd0, 1'b0);
        step();
        applyStimulus(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_row = 2'd0; cfg_id = 4'd5;
        mid();
        checkOutput("stall_pe_en", 32'(bi.pe_en), 32'b111);
        step(); cfg_we = 1'b0;
        mid(); step(); mid();
        checkOutput("stall_in_ready", 32'(bi.in_ready), 32'd0);
        step(); flush = 1'b1;
        mid();
        checkOutput("flush_in_ready", 32'(bi.in_ready), 32'd0);
        step(); flush = 1'b0;
        mid();
        checkOutput("flush_busy", 32'(busy), 32'd0);
        checkOutput("flush_pe_en", 32'(bi.pe_en), 32'd0);
        checkOutput("flush_beat_cnt", 32'(beat_cnt), 32'd0);
        checkOutput("flush_done", 32'(done), 32'd0);
        step();
        bi.pe_ready = '1;
        applyStimulus(1'b1, 16'h7777, 4'd0, 4'd0, 1'b1);
        step();
        applyStimulus(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
        mid();
        checkOutput("cfg_gated_pe_en", 32'(bi.pe_en), 32'b111);
        step(); mid();
        checkOutput("cfg_gated_done", 32'(done), 32'd1);
        checkOutput("cfg_gated_drop", 32'(drop), 32'd0);
        step();

        // Async reset mid-SEND, then tables must read back as all zero.
        cfgWrite(1'b1, 2, 2, 9);
        bi.pe_ready = '0;
        applyStimulus(1'b1, 16'h9999, 4'd0, 4'd0, 1'b0);
        step();
        applyStimulus(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
        mid();
        checkOutput("arst_pre_busy", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        checkOutput("arst_pe_en", 32'(bi.pe_en), 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_in_ready", 32'(bi.in_ready), 32'd1);
        checkOutput("arst_bus_data", 32'(bi.bus_data), 32'd0);
        step(); step();
        rst = 1'b0;
        bi.pe_ready = '1;
        applyStimulus(1'b1, 16'h4242, 4'd0, 4'd0, 1'b0);
        step();
        applyStimulus(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
        mid();
        checkOutput("arst_tables_zero", 32'(bi.pe_en), 32'h1FF);
        step(); mid();
        checkOutput("arst_final_cnt", 32'(beat_cnt), 32'd1);
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/xbus_mcast_tx.md
Name: xbus_mcast_tx

Overview:
- Transmitter end of the per-row X-bus used by the configurable PE array.
- Accepts a tagged data stream from the global buffer (data + row tag + column tag).
- Multicasts each word to every PE whose programmed row/column IDs match the tags, using a per-PE enable/ready handshake.
- A word retires only when every targeted PE has accepted it. This block is the source that the row bus controllers and PE receivers consume from.

Parameters:
- DATA_WIDTH, 16, payload width in bits.
- NUM_ROW, 3, PE array rows.
- NUM_COL, 3, PE array columns.
- ID_WIDTH, 4, width of row/column tags and ID table entries.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort of the current word; ID tables kept.
- cfg_we  in  1  ID table write strobe.
- cfg_sel  in  1  0 = row-ID table, 1 = column-ID table.
- cfg_row  in  $clog2(NUM_ROW)  table row index.
- cfg_col  in  $clog2(NUM_COL)  table column index (column table only).
- cfg_id  in  ID_WIDTH  ID value written.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid & in_ready.
- in_data  in  DATA_WIDTH  payload.
- in_row_tag  in  ID_WIDTH  destination row tag.
- in_col_tag  in  ID_WIDTH  destination column tag.
- in_last  in  1  final word of the tile.
- bus_data  out  DATA_WIDTH  broadcast payload, shared by all rows.
- pe_en  out  NUM_ROW*NUM_COL  per-PE valid, index r*NUM_COL+c.
- pe_ready  in  NUM_ROW*NUM_COL  per-PE ready, same indexing.
- busy  out  1  high while in SEND.
- done  out  1  one-cycle pulse when the in_last word retires.
- drop  out  1  one-cycle pulse when a word has zero targets.
- beat_cnt  out  16  words retired since last done, flush or reset.

Behaviour:
- Reset (rst=1, async):
  - State IDLE.
  - in_ready=1, pe_en=0, bus_data=0, busy=0, done=0, drop=0, beat_cnt=0.
  - acked mask = 0; all ID table entries = 0.
- Tables:
  - Row-ID table: NUM_ROW entries.
  - Column-ID table: NUM_ROW*NUM_COL entries.
  - cfg_we is honoured only in IDLE and ignored otherwise. A write is visible from the next cycle.
- Target mask:
  - tgt[r*NUM_COL+c] = (rowid[r]==row_tag_q) & (colid[r][c]==col_tag_q).
  - Computed combinationally from the registered tags.
- FSM states: IDLE, SEND.
  - IDLE: in_ready=1. On in_valid, capture data/tags/last into registers, clear acked, go to SEND.
  - SEND:
    - pe_en = tgt & ~acked; bus_data = data_q.
    - accepted = pe_en & pe_ready; acked <= acked | accepted.
    - beat_done = ((acked | accepted) & tgt) == tgt.
    - in_ready = beat_done.
    - On beat_done: beat_cnt += 1, and done pulses if last_q (beat_cnt then clears to 0).
    - On beat_done with in_valid: capture the next word, clear acked, stay in SEND (back-to-back, 1 word/cycle).
    - On beat_done without in_valid: go to IDLE.
- Empty target (tgt==0):
  - beat_done in the first SEND cycle and drop pulses; pe_en stays 0.
  - The word counts in beat_cnt; done still pulses if it was last.
- Latency: input accept to first pe_en = 1 cycle. A word with all targets ready retires in that same cycle.
- Partial acceptance: acked PEs see pe_en drop the cycle after their accept and are never re-offered the same word.
- bus_data and pe_en hold stable until retirement.
- flush:
  - In any state: next state IDLE, acked=0, pe_en=0, beat_cnt=0, no done/drop pulse.
  - in_ready is forced 0 during the flush cycle.
  - flush has priority over beat_done and cfg_we.
- beat_cnt wraps modulo 2^16.
- rst mid-SEND aborts immediately (async); outputs take their reset values within the same cycle.

Test Plan:
- Unicast. Rows=0,1,2; cols[r][c]=c. Send data 0x1234, row_tag=1, col_tag=2, all ready → pe_en=bit5 for 1 cycle, in_ready=1 that cycle, beat_cnt=1.
- Multicast with staggered ready. Cols all 0; send row_tag=0, col_tag=0. pe_ready bit0 at cycle1, bit1 at cycle3, bit2 at cycle4 → pe_en 0b111→0b110→0b110→0b100→0; retire at cycle4, bit0 offered once.
- Back-to-back. 4 words, last on the 4th, all targets always ready → one word retired per cycle, in_ready held 1, done pulses with the 4th word, beat_cnt returns to 0.
- Drop. row_tag=7 with no matching row → drop=1 one cycle, pe_en stays 0, word counted.
- Flush and config gating. Word stalled (pe_ready=0) for 3 cycles, then flush → IDLE next cycle, pe_en=0, beat_cnt=0, no done. A cfg_we issued while stalled is ignored (table readback unchanged).
- Async reset. rst mid-SEND → pe_en=0 and busy=0 without waiting for a clk edge; ID tables read 0.
